// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start(0), WIDTH data bits, even parity, stop(1).
// Completed words are handed downstream through a single-entry valid/ready buffer.
module serial_frame_rx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             sdin,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_dout,
    output logic             out_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             p_bit_q, p_bit_d;
    logic             good_stop;
    logic             bad_stop;
    logic             buf_free;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        p_bit_d   = p_bit_q;
        good_stop = 1'b0;
        bad_stop  = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!sdin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        sh_d    = '0;
                    end
                end
                DATA: begin
                    if (LSB_FIRST)
                        sh_d = {sdin, sh_q[WIDTH-1:1]};
                    else
                        sh_d = {sh_q[WIDTH-2:0], sdin};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1))
                        state_d = PARITY;
                end
                PARITY: begin
                    p_bit_d = sdin;
                    state_d = STOP;
                end
                STOP: begin
                    good_stop = sdin;
                    bad_stop  = !sdin;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            p_bit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            p_bit_q <= p_bit_d;
        end
    end

    // The buffer can take a new word if empty or being drained on this same edge.
    assign buf_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_dout     <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= good_stop && !buf_free;
            if (good_stop && buf_free) begin
                p_dout     <= sh_q;
                parity_err <= (^sh_q) ^ p_bit_q;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=4, LSB-first): good frame, parity,
// framing, overrun, strobe gaps, back-to-back frames and reset mid-frame.
module tb_serial_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       sdin;
    logic       out_ready;
    logic [3:0] p_dout;
    logic       out_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    serial_frame_rx #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .sdin       (sdin),
        .out_ready  (out_ready),
        .p_dout     (p_dout),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (overrun)   ov_cnt = ov_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle for 'gaps' cycles with bit_en=0, then present bit b for one strobe.
    task automatic send_bit(input logic b, input int gaps);
        bit_en = 1'b0;
        sdin   = 1'b1;
        for (int g = 0; g < gaps; g++) tick();
        bit_en = 1'b1;
        sdin   = b;
        tick();
        bit_en = 1'b0;
        sdin   = 1'b1;
    endtask

    task automatic send_frame(input logic [3:0] data, input logic par, input logic stp, input int gaps);
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(data[i], gaps);
        send_bit(par, gaps);
        send_bit(stp, gaps);
    endtask

    task automatic accept_word();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bit_en = 1'b0; sdin = 1'b1; out_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({p_dout, out_valid, parity_err, frame_err, overrun, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {p_dout, out_valid, parity_err, frame_err, overrun, busy}, 9'b0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        send_bit(1'b0, 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_after_start: got %b expected 1", busy); end
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL good_valid_before_stop: got %b expected 0", out_valid); end
        send_bit(1'b1, 0);
        checks++;
        if (p_dout !== 4'hA) begin errors++; $display("FAIL good_dout: got %h expected a", p_dout); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b expected 1", out_valid); end
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL good_parity_err: got %b expected 0", parity_err); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL good_frame_err: got %b expected 0", frame_err); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after_stop: got %b expected 0", busy); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL good_valid_held: got %b expected 1", out_valid); end
        accept_word();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL good_accept: got %b expected 0", out_valid); end
    endtask

    task automatic test_parity_error();
        send_frame(4'h7, 1'b0, 1'b1, 0);
        checks++;
        if (p_dout !== 4'h7) begin errors++; $display("FAIL parity_dout: got %h expected 7", p_dout); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL parity_valid: got %b expected 1", out_valid); end
        checks++;
        if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_err: got %b expected 1", parity_err); end
        accept_word();
    endtask

    task automatic test_frame_error();
        send_frame(4'h5, 1'b0, 1'b0, 0);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_pulse: got %b expected 1", frame_err); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_valid: got %b expected 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy: got %b expected 0", busy); end
        tick();
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_width: got %b expected 0", frame_err); end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b1, 0);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_first: got %b expected 0", overrun); end
        send_frame(4'hC, 1'b0, 1'b1, 0);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b expected 1", overrun); end
        checks++;
        if (p_dout !== 4'h3) begin errors++; $display("FAIL overrun_dout: got %h expected 3", p_dout); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", out_valid); end
        tick();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_width: got %b expected 0", overrun); end
        accept_word();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_strobe_gaps();
        send_bit(1'b0, 0);
        send_bit(1'b0, 3); send_bit(1'b1, 3); send_bit(1'b0, 3); send_bit(1'b1, 3);
        send_bit(1'b0, 3);
        for (int g = 0; g < 3; g++) tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gaps_before_stop: got valid=%b busy=%b expected valid=0 busy=1", out_valid, busy);
        end
        send_bit(1'b1, 0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid_edge: got %b expected 1", out_valid); end
        checks++;
        if (p_dout !== 4'hA || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_word: got %h/%b expected a/0", p_dout, parity_err);
        end
        accept_word();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_frame(4'h5, 1'b0, 1'b1, 0);
        checks++;
        if (p_dout !== 4'h5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got %h/%b expected 5/1", p_dout, out_valid);
        end
        send_frame(4'hA, 1'b0, 1'b1, 0);
        checks++;
        if (p_dout !== 4'hA || out_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got %h/%b/%b expected a/1/0", p_dout, out_valid, overrun);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int fe0;
        int ov0;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b valid=%b expected 0/0", busy, out_valid);
        end
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(4'h5, 1'b0, 1'b1, 0);
        checks++;
        if (p_dout !== 4'h5 || out_valid !== 1'b1 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_word: got %h/%b/%b expected 5/1/0", p_dout, out_valid, parity_err);
        end
        accept_word();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_one_word: got %b expected 0", out_valid); end
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL midreset_pulses: got fe=%0d ov=%0d expected 0/0", fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_frame_error();
        test_overrun();
        test_strobe_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial receiver that deserializes a bit stream from a shift-register transmitter into a parallel word. Frame format is start bit (0), WIDTH data bits, even-parity bit, stop bit (1). The line idles high. The block sits on the receive side of the serial link and hands completed words downstream over a valid/ready handshake with a single-entry output buffer. It flags parity errors, framing errors and overruns.

## Interface
- WIDTH, 4: data bits per frame; legal values are 2 to 16.
- LSB_FIRST, 1: 1 means the first data bit received is bit 0; 0 means the first data bit received is bit WIDTH-1.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- bit_en  in  1  bit strobe; sdin is sampled only on cycles where bit_en=1.
- sdin  in  1  serial data line; idle level is 1.
- out_ready  in  1  downstream accepts the word when out_valid=1 and out_ready=1.
- p_dout  out  WIDTH  received word, held stable while out_valid=1.
- out_valid  out  1  p_dout holds an unaccepted word.
- parity_err  out  1  parity mismatch for the word in p_dout; meaningful only while out_valid=1.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  out  1  one-cycle pulse when a good frame is dropped because the buffer is full.
- busy  out  1  high in any state other than IDLE.

## Operation
- States are IDLE, DATA, PARITY and STOP. All transitions happen only on bit_en=1 cycles; on bit_en=0 cycles the FSM, shift register and bit counter hold.
- IDLE: sampling sdin=0 enters DATA, clears the bit counter and clears the shift register. Sampling sdin=1 stays in IDLE.
- DATA: each sample shifts into the shift register.
  - LSB_FIRST=1: sh <= {sdin, sh[WIDTH-1:1]}.
  - LSB_FIRST=0: sh <= {sh[WIDTH-2:0], sdin}.
  - The counter increments on each sample. The WIDTH-th sample moves to PARITY.
- PARITY: the sampled bit is stored as p_bit. The expected value is the XOR of all data bits (even parity). The state then moves to STOP.
- STOP, good frame (sdin=1): the frame is delivered to the output buffer. The state returns to IDLE.
- STOP, bad frame (sdin=0): the word is discarded, frame_err pulses for one cycle, and out_valid, p_dout and parity_err are unchanged. The state returns to IDLE.
- Delivering a good frame:
  - If the buffer is free (out_valid=0, or out_valid=1 with out_ready=1 on the same cycle): p_dout <= sh, parity_err <= (^sh) ^ p_bit, out_valid <= 1.
  - If the buffer is full (out_valid=1 and out_ready=0): the new word is dropped, overrun pulses for one cycle, and the held word and its parity_err are unchanged.
- Handshake: when out_valid=1 and out_ready=1 with no delivery on that cycle, out_valid <= 0 on the next edge. p_dout and parity_err keep their last values but are don't-care while out_valid=0.
- Once out_valid=1, p_dout must not change until that word is accepted.
- A start bit is never detected during DATA, PARITY or STOP. The next frame's start bit can be sampled on the very next bit_en after STOP.

## Timing
- Reset values: p_dout=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. Reset also forces FSM=IDLE and clears the counter and shift register.
- Reset mid-frame aborts the frame with no error pulse. The next frame is received normally.
- Latency: out_valid rises at the edge on which the stop bit is sampled, so it is visible in the following cycle. A full frame takes WIDTH+3 bit_en samples.
- frame_err and overrun are high for exactly one clk cycle, registered at the stop-sample edge.
- Back-to-back strobes (bit_en=1 every cycle) must work with no gap cycles required.
- busy goes high the cycle after the start-bit sample and goes low the cycle after the stop-bit sample.

## Test plan
All scenarios use WIDTH=4 and LSB_FIRST=1.
- Good frame with bit_en=1 every cycle: send 0,0,1,0,1,0,1 (start, data 4'hA LSB-first, parity 0, stop), with out_ready=0. Required: p_dout=4'hA, out_valid=1, parity_err=0, frame_err=0.
- Parity error: send data 4'h7 with parity bit 0 and stop 1. Required: p_dout=4'h7, out_valid=1, parity_err=1.
- Framing error: send data 4'h5 with parity 0 and stop 0. Required: frame_err pulses for one cycle, out_valid stays 0, busy=0 afterwards.
- Overrun: hold out_ready=0 and send 4'h3 then 4'hC. Required: overrun pulses once, and p_dout stays 4'h3. Then raise out_ready for one cycle; required: out_valid=0.
- Strobe gaps: send 4'hA with 3 bit_en=0 cycles between every bit. Required: the same result as the first scenario, and out_valid rises at the stop-sample edge.
- Reset mid-frame: assert rst_n=0 for one cycle after 2 data bits, then send a clean frame of 4'h5. Required: exactly one word, 4'h5, with no frame_err and no overrun.
